// File: rtl/config_sequencer_if.sv
// config_sequencer_if: host, bitstream memory and fabric config bus signals of config_sequencer
//    master : sequencer side (drives mem_rd_en/mem_addr, config bus, status)
//    slave  : host/memory/fabric side (drives start, base_addr, num_words, abort, mem_rdata, config_stall)
interface config_sequencer_if #(parameter int MEM_AW = 10);
   logic              start;
   logic [MEM_AW-1:0] base_addr;
   logic [MEM_AW:0]   num_words;
   logic              abort;
   logic              mem_rd_en;
   logic [MEM_AW-1:0] mem_addr;
   logic [63:0]       mem_rdata;
   logic [31:0]       config_addr;
   logic [31:0]       config_data;
   logic              config_valid;
   logic              config_stall;
   logic              busy;
   logic              done;
   logic [MEM_AW:0]   word_count;
   logic [31:0]       checksum;
   modport master (
      input  start, base_addr, num_words, abort, mem_rdata, config_stall,
      output mem_rd_en, mem_addr, config_addr, config_data, config_valid, busy, done, word_count, checksum
   );
   modport slave (
      output start, base_addr, num_words, abort, mem_rdata, config_stall,
      input  mem_rd_en, mem_addr, config_addr, config_data, config_valid, busy, done, word_count, checksum
   );
endinterface

// File: rtl/config_sequencer.sv
// config_sequencer: streams {addr,data} words from bitstream memory onto the fabric config bus
//    clk, reset : clock, synchronous active-high reset
//    bus        : config_sequencer_if.master (start/abort control, memory read port, config bus, status)
//    Optional: define CONFIG_CHECKSUM_EN to build the running XOR checksum; otherwise checksum is 0.
module config_sequencer #(
   parameter int MEM_AW      = 10,
   parameter int HOLD_CYCLES = 1,
   parameter int GAP_CYCLES  = 0
) (
   input logic clk,
   input logic reset,
   config_sequencer_if.master bus
);
   localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
   localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
   localparam logic [MEM_AW:0] ONE = 1;
   typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, ISSUE, GAP, DONE} state_t;
   state_t            state, nxt;
   logic [MEM_AW-1:0] base;
   logic [MEM_AW:0]   num, wcnt;
   logic [HW-1:0]     hold_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [31:0]       cfg_addr, cfg_data;
   logic              go, accept, gap_end, more;
   assign go      = state == IDLE && bus.start && !bus.abort;
   assign accept  = state == ISSUE && !bus.config_stall && hold_cnt == HW'(HOLD_CYCLES - 1);
   assign gap_end = gap_cnt == GW'(GAP_CYCLES - 1);
   // word count doubles as the read index; in ISSUE it has not yet been bumped for the current word
   assign more    = (state == ISSUE ? wcnt + ONE : wcnt) != num;
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:      if (go) nxt = bus.num_words == '0 ? DONE : FETCH;
         FETCH:     nxt = WAIT_DATA;
         WAIT_DATA: nxt = ISSUE;
         ISSUE:     if (accept) nxt = GAP_CYCLES > 0 ? GAP : more ? FETCH : DONE;
         GAP:       if (gap_end) nxt = more ? FETCH : DONE;
         DONE:      nxt = IDLE;
         default:   nxt = IDLE;
      endcase
      if (bus.abort && state != IDLE) nxt = IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         base     <= '0;
         num      <= '0;
         wcnt     <= '0;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         cfg_addr <= '0;
         cfg_data <= '0;
      end else begin
         state <= nxt;
         if (go) begin
            base <= bus.base_addr;
            num  <= bus.num_words;
            wcnt <= '0;
         end
         if (state == WAIT_DATA) begin
            {cfg_addr, cfg_data} <= bus.mem_rdata;
            hold_cnt             <= '0;
         end
         if (state == ISSUE && !bus.config_stall) hold_cnt <= accept ? '0 : hold_cnt + HW'(1);
         // acceptance counts even when abort arrives in the same cycle
         if (accept) begin
            wcnt    <= wcnt + ONE;
            gap_cnt <= '0;
         end
         if (state == GAP) gap_cnt <= gap_cnt + GW'(1);
      end
   end
`ifdef CONFIG_CHECKSUM_EN
   logic [31:0] csum;
   always_ff @(posedge clk) begin
      if (reset || go) csum <= '0;
      else if (accept) csum <= csum ^ cfg_addr ^ cfg_data;
   end
   assign bus.checksum = csum;
`else
   assign bus.checksum = '0;
`endif
   assign bus.mem_rd_en    = state == FETCH;
   assign bus.mem_addr     = state == FETCH ? base + wcnt[MEM_AW-1:0] : '0;
   assign bus.config_valid = state == ISSUE;
   assign bus.config_addr  = cfg_addr;
   assign bus.config_data  = cfg_data;
   assign bus.busy         = state != IDLE;
   assign bus.done         = state == DONE;
   assign bus.word_count   = wcnt;
endmodule

// File: tb/tb_config_sequencer.sv
// tb_config_sequencer: directed self-checking bench for config_sequencer
module tb_config_sequencer;
   localparam int AW = 10;
   logic clk = 0;
   logic reset = 1;
   int   n_vec = 0;
   int   n_bad = 0;
   logic [63:0] mem [0:(1<<AW)-1];
   always #5 clk = ~clk;
   config_sequencer_if #(.MEM_AW(AW)) bus ();
   config_sequencer #(.MEM_AW(AW), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic launch(input logic [AW-1:0] b, input logic [AW:0] n);
      bus.base_addr = b;
      bus.num_words = n;
      bus.start     = 1;
      @(negedge clk);
      bus.start     = 0;
   endtask
   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      logic [63:0]   w [3];
      logic [AW-1:0] addrs [4];
      int nv, done_at, dn, k;
      logic rd, v;
      for (int i = 0; i < (1 << AW); i++) mem[i] = {32'h0100_0000 | 32'(i), ~32'(i)};
      w[0] = 64'h0001_0010_DEAD_0000;
      w[1] = 64'h0001_0011_DEAD_0001;
      w[2] = 64'h0002_0012_DEAD_0002;
      for (int i = 0; i < 3; i++) mem[16 + i] = w[i];
      mem[10'h050] = {32'h0001_0001, 32'hA5A5_A5A5};
      mem[10'h051] = {32'h0001_0002, 32'h0000_FFFF};
      // reset with random inputs
      bus.start        = 1'($urandom);
      bus.abort        = 1'($urandom);
      bus.config_stall = 1'($urandom);
      bus.base_addr    = AW'($urandom);
      bus.num_words    = (AW+1)'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ctl", {bus.mem_rd_en, bus.config_valid, bus.busy, bus.done}, 0);
      check("rst_maddr", bus.mem_addr, 0);
      check("rst_cfg", {bus.config_addr, bus.config_data}, 0);
      check("rst_wc", bus.word_count, 0);
      check("rst_csum", bus.checksum, 0);
      bus.start = 0; bus.abort = 0; bus.config_stall = 0; bus.base_addr = 0; bus.num_words = 0;
      reset = 0;
      @(negedge clk);
      // three words, no stall
      launch(10'h010, 3);
      for (int c = 1; c <= 11; c++) begin
         check("t2_rd", bus.mem_rd_en, (c == 1 || c == 4 || c == 7));
         if (c == 1 || c == 4 || c == 7) check("t2_maddr", bus.mem_addr, 10'h010 + (c - 1) / 3);
         check("t2_valid", bus.config_valid, (c % 3 == 0 && c <= 9));
         if (c % 3 == 0 && c <= 9) check("t2_word", {bus.config_addr, bus.config_data}, w[c / 3 - 1]);
         check("t2_done", bus.done, c == 10);
         check("t2_busy", bus.busy, c <= 10);
         if (c == 11) check("t2_wc", bus.word_count, 3);
         @(negedge clk);
      end
      // one word stalled for four cycles
      launch(10'h020, 1);
      nv = 0; done_at = 0;
      for (int c = 1; c <= 10; c++) begin
         bus.config_stall = (c >= 3 && c <= 6);
         if (bus.config_valid) begin
            nv++;
            check("t3_word", {bus.config_addr, bus.config_data}, mem[10'h020]);
         end
         if (bus.done) done_at = c;
         @(negedge clk);
      end
      bus.config_stall = 0;
      check("t3_nvalid", nv, 5);
      check("t3_done_at", done_at, 8);
      check("t3_wc", bus.word_count, 1);
      // zero-length load
      launch(10'h030, 0);
      rd = 0; v = 0;
      for (int c = 1; c <= 4; c++) begin
         check("t4_done", bus.done, c == 1);
         rd |= bus.mem_rd_en;
         v  |= bus.config_valid;
         @(negedge clk);
      end
      check("t4_rd", rd, 0);
      check("t4_valid", v, 0);
      // address wrap
      launch(10'h3FE, 4);
      k = 0; dn = 0; done_at = 0;
      for (int c = 1; c <= 16; c++) begin
         if (bus.mem_rd_en && k < 4) begin
            addrs[k] = bus.mem_addr;
            k++;
         end
         if (bus.done) begin
            dn++;
            done_at = c;
         end
         @(negedge clk);
      end
      check("t5_nrd", k, 4);
      check("t5_a0", addrs[0], 10'h3FE);
      check("t5_a1", addrs[1], 10'h3FF);
      check("t5_a2", addrs[2], 10'h000);
      check("t5_a3", addrs[3], 10'h001);
      check("t5_ndone", dn, 1);
      check("t5_done_at", done_at, 13);
      check("t5_wc", bus.word_count, 4);
      // ignored restart, then abort while stalled
      launch(10'h040, 5);
      check("t6_wc_clr", bus.word_count, 0);
      @(negedge clk);
      bus.base_addr = 10'h100; bus.num_words = 1; bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      check("t6_w0_valid", bus.config_valid, 1);
      check("t6_w0_addr", bus.config_addr, mem[10'h040][63:32]);
      @(negedge clk);
      check("t6_maddr1", bus.mem_addr, 10'h041);
      repeat (2) @(negedge clk);
      bus.config_stall = 1;
      check("t6_w1_valid", bus.config_valid, 1);
      @(negedge clk);
      bus.abort = 1;
      @(negedge clk);
      bus.abort = 0; bus.config_stall = 0;
      check("t6_valid", bus.config_valid, 0);
      check("t6_busy", bus.busy, 0);
      dn = 0;
      for (int c = 0; c < 4; c++) begin
         dn += int'(bus.done);
         @(negedge clk);
      end
      check("t6_nodone", dn, 0);
      check("t6_wc", bus.word_count, 1);
      // checksum over two words
      launch(10'h050, 2);
      repeat (6) @(negedge clk);
      check("t7_done", bus.done, 1);
      check("t7_wc", bus.word_count, 2);
`ifdef CONFIG_CHECKSUM_EN
      check("t7_csum", bus.checksum, 32'hA5A5_5A59);
`else
      check("t7_csum", bus.checksum, 0);
`endif
      @(negedge clk);
      check("t7_idle", bus.busy, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
